// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths and memory-arbiter state encodings for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int InstAddrBus = 32;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbIf   = 2'd1,
        ArbMem  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pipe_ctrl_mem_arbiter.sv
// mem_arbiter: shares the single memory-controller port between fetch and MEM-stage accesses.
module mem_arbiter
    import pipe_ctrl_pkg::*;
#(
    parameter bit MEM_PRIO = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req,
    input  logic       mem_req,
    input  logic       memctrl_done,
    output arb_state_e state,
    output logic       if_done,
    output logic       mem_done,
    output logic       grant_if,
    output logic       grant_mem
);

    arb_state_e state_q, state_d;
    logic       grant_if_q, grant_if_d;
    logic       grant_mem_q, grant_mem_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ArbIdle;
            grant_if_q  <= 1'b0;
            grant_mem_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_if_q  <= grant_if_d;
            grant_mem_q <= grant_mem_d;
        end
    end

    // Every access returns through IDLE, which gives back-to-back requests one dead cycle.
    always_comb begin
        state_d = (state_q == ArbIdle)
                ? ((mem_req && (MEM_PRIO || !if_req)) ? ArbMem : (if_req ? ArbIf : ArbIdle))
                : (memctrl_done ? ArbIdle : state_q);
    end

    always_comb begin
        grant_if_d  = (state_q == ArbIf) && !memctrl_done;
        grant_mem_d = (state_q == ArbMem) && !memctrl_done;
        if_done     = (state_q == ArbIf) && memctrl_done;
        mem_done    = (state_q == ArbMem) && memctrl_done;
    end

    assign state     = state_q;
    assign grant_if  = grant_if_q;
    assign grant_mem = grant_mem_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble/flush generation for the 5-stage pipeline plus deferred branch redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W   = InstAddrBus,
    parameter bit MEM_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic              mem_req,
    input  logic              memctrl_done,
    input  logic              id_load_use,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic              grant_if,
    output logic              grant_mem,
    output logic              if_data_valid,
    output logic              if_stall,
    output logic              ifid_stall,
    output logic              idex_stall,
    output logic              id_stall,
    output logic              exmem_stall,
    output logic              branch_interception,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target
);

    arb_state_e        state;
    logic              if_done, mem_done;
    logic              mem_busy, load_use, fetch_wait, issue;
    logic              redirect_pending_q, redirect_pending_d;
    logic              drop_fetch_q, drop_fetch_d;
    logic              pc_redirect_q, pc_redirect_d;
    logic [ADDR_W-1:0] pc_target_q, pc_target_d;

    mem_arbiter #(.MEM_PRIO(MEM_PRIO)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .mem_req      (mem_req),
        .memctrl_done (memctrl_done),
        .state        (state),
        .if_done      (if_done),
        .mem_done     (mem_done),
        .grant_if     (grant_if),
        .grant_mem    (grant_mem)
    );

    // A MEM stall freezes EX, so a taken branch simply waits there until the stall lifts.
    always_comb begin
        mem_busy            = mem_req && !mem_done;
        branch_interception = !mem_busy && ex_branch_taken;
        load_use            = !mem_busy && !ex_branch_taken && id_load_use;
        fetch_wait          = !mem_busy && !ex_branch_taken && !id_load_use
                              && (state == ArbIf) && !memctrl_done;
        if_stall            = mem_busy || load_use || fetch_wait;
        ifid_stall          = mem_busy || load_use;
        idex_stall          = mem_busy;
        exmem_stall         = mem_busy;
        id_stall            = load_use;
        if_data_valid       = if_done && !drop_fetch_q;
    end

    always_comb begin
        issue              = redirect_pending_q && (state != ArbIf);
        redirect_pending_d = branch_interception || (redirect_pending_q && !issue);
        pc_redirect_d      = issue;
        pc_target_d        = branch_interception ? ex_branch_target : pc_target_q;
        drop_fetch_d       = (branch_interception && (state == ArbIf) && !memctrl_done)
                             || (drop_fetch_q && !if_done);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            redirect_pending_q <= 1'b0;
            drop_fetch_q       <= 1'b0;
            pc_redirect_q      <= 1'b0;
            pc_target_q        <= '0;
        end else begin
            redirect_pending_q <= redirect_pending_d;
            drop_fetch_q       <= drop_fetch_d;
            pc_redirect_q      <= pc_redirect_d;
            pc_target_q        <= pc_target_d;
        end
    end

    assign pc_redirect = pc_redirect_q;
    assign pc_target   = pc_target_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, if_req, mem_req, memctrl_done, id_load_use, ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        grant_if, grant_mem, if_data_valid, if_stall, ifid_stall, idex_stall;
    logic        id_stall, exmem_stall, branch_interception, pc_redirect;
    logic [31:0] pc_target;
    logic [9:0]  obs;

    typedef struct {
        string       tag;
        logic [9:0]  o;
        logic [31:0] t;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(32), .MEM_PRIO(1'b1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_req              (if_req),
        .mem_req             (mem_req),
        .memctrl_done        (memctrl_done),
        .id_load_use         (id_load_use),
        .ex_branch_taken     (ex_branch_taken),
        .ex_branch_target    (ex_branch_target),
        .grant_if            (grant_if),
        .grant_mem           (grant_mem),
        .if_data_valid       (if_data_valid),
        .if_stall            (if_stall),
        .ifid_stall          (ifid_stall),
        .idex_stall          (idex_stall),
        .id_stall            (id_stall),
        .exmem_stall         (exmem_stall),
        .branch_interception (branch_interception),
        .pc_redirect         (pc_redirect),
        .pc_target           (pc_target)
    );

    // Bit order: grant_if grant_mem if_data_valid | if ifid idex id exmem stalls | intercept redirect
    assign obs = {grant_if, grant_mem, if_data_valid, if_stall, ifid_stall, idex_stall,
                  id_stall, exmem_stall, branch_interception, pc_redirect};

    task automatic step(input string tag, input logic r, input logic i, input logic m,
                        input logic d, input logic lu, input logic bt, input logic [31:0] tg,
                        input logic [9:0] eo, input logic [31:0] et);
        exp_t e;
        rst = r; if_req = i; mem_req = m; memctrl_done = d;
        id_load_use = lu; ex_branch_taken = bt; ex_branch_target = tg;
        e.tag = tag; e.o = eo; e.t = et;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_assert++;
        assert (obs === e.o) else begin
            n_fail++;
            $error("FAIL %s ctrl got %b exp %b", e.tag, obs, e.o);
        end
        n_assert++;
        assert (pc_target === e.t) else begin
            n_fail++;
            $error("FAIL %s pc_target got %h exp %h", e.tag, pc_target, e.t);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b1; mem_req = 1'b0; memctrl_done = 1'b0;
        id_load_use = 1'b0; ex_branch_taken = 1'b0; ex_branch_target = '0;
        @(posedge clk);
        @(negedge clk);
        // reset and a plain fetch
        step("rst_hold",   0, 1, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h0);
        step("rst_rel",    1, 1, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h0);
        step("if_enter",   1, 1, 0, 0, 0, 0, 0, 10'b000_10000_00, 32'h0);
        step("if_grant",   1, 1, 0, 0, 0, 0, 0, 10'b100_10000_00, 32'h0);
        step("if_done",    1, 0, 0, 1, 0, 0, 0, 10'b101_00000_00, 32'h0);
        step("if_drop_gr", 1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h0);
        // simultaneous requests, MEM wins
        step("both_idle",  1, 1, 1, 0, 0, 0, 0, 10'b000_11101_00, 32'h0);
        step("mem_enter",  1, 1, 1, 0, 0, 0, 0, 10'b000_11101_00, 32'h0);
        step("mem_grant",  1, 1, 1, 0, 0, 0, 0, 10'b010_11101_00, 32'h0);
        step("mem_done",   1, 1, 1, 1, 0, 0, 0, 10'b010_00000_00, 32'h0);
        step("dead_cyc",   1, 1, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h0);
        step("if2_enter",  1, 1, 0, 0, 0, 0, 0, 10'b000_10000_00, 32'h0);
        step("if2_grant",  1, 1, 0, 0, 0, 0, 0, 10'b100_10000_00, 32'h0);
        step("if2_done",   1, 0, 0, 1, 0, 0, 0, 10'b101_00000_00, 32'h0);
        // load-use bubble
        step("load_use",   1, 0, 0, 0, 1, 0, 0, 10'b000_11010_00, 32'h0);
        step("lu_clear",   1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h0);
        // branch during a fetch
        step("br_pre",     1, 1, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h0);
        step("br_take",    1, 1, 0, 0, 0, 1, 32'h1040, 10'b000_00000_10, 32'h0);
        step("br_wait1",   1, 1, 0, 0, 0, 0, 0, 10'b100_10000_00, 32'h1040);
        step("br_wait2",   1, 1, 0, 0, 0, 0, 0, 10'b100_10000_00, 32'h1040);
        step("br_squash",  1, 0, 0, 1, 0, 0, 0, 10'b100_00000_00, 32'h1040);
        step("br_idle",    1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h1040);
        step("br_redir",   1, 0, 0, 0, 0, 0, 0, 10'b000_00000_01, 32'h1040);
        step("br_once",    1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h1040);
        // branch held under a MEM stall
        step("ms_idle",    1, 0, 1, 0, 0, 1, 32'h2000, 10'b000_11101_00, 32'h1040);
        step("ms_enter",   1, 0, 1, 0, 0, 1, 32'h2000, 10'b000_11101_00, 32'h1040);
        step("ms_grant",   1, 0, 1, 0, 0, 1, 32'h2000, 10'b010_11101_00, 32'h1040);
        step("ms_release", 1, 0, 1, 1, 0, 1, 32'h2000, 10'b010_00000_10, 32'h1040);
        step("ms_idle2",   1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h2000);
        step("ms_redir",   1, 0, 0, 0, 0, 0, 0, 10'b000_00000_01, 32'h2000);
        step("ms_once",    1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h2000);
        // two branches before the redirect issues
        step("bb_pre",     1, 1, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h2000);
        step("bb_first",   1, 1, 0, 0, 0, 1, 32'h100, 10'b000_00000_10, 32'h2000);
        step("bb_wait",    1, 1, 0, 0, 0, 0, 0, 10'b100_10000_00, 32'h100);
        step("bb_second",  1, 1, 0, 0, 0, 1, 32'h200, 10'b100_00000_10, 32'h100);
        step("bb_squash",  1, 0, 0, 1, 0, 0, 0, 10'b100_00000_00, 32'h200);
        step("bb_idle",    1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h200);
        step("bb_redir",   1, 0, 0, 0, 0, 0, 0, 10'b000_00000_01, 32'h200);
        step("bb_once",    1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h200);
        // done while idle is ignored; branch coinciding with fetch completion
        step("idle_done",  1, 0, 0, 1, 0, 0, 0, 10'b000_00000_00, 32'h200);
        step("bd_pre",     1, 1, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h200);
        step("bd_enter",   1, 1, 0, 0, 0, 0, 0, 10'b000_10000_00, 32'h200);
        step("bd_same",    1, 0, 0, 1, 0, 1, 32'h300, 10'b101_00000_10, 32'h200);
        step("bd_idle",    1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h300);
        step("bd_redir",   1, 0, 0, 0, 0, 0, 0, 10'b000_00000_01, 32'h300);
        // reset in the middle of a fetch
        step("ra_pre",     1, 1, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h300);
        step("ra_enter",   1, 1, 0, 0, 0, 0, 0, 10'b000_10000_00, 32'h300);
        step("ra_reset",   0, 1, 0, 0, 0, 0, 0, 10'b100_10000_00, 32'h300);
        step("ra_after",   1, 0, 0, 0, 0, 0, 0, 10'b000_00000_00, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and stall controller for the 5-stage RISC-V pipeline.
- Generates the per-stage stall, bubble and flush controls consumed by the IF, IF/ID, ID/EX and EX/MEM registers: if_stall, ifid_stall, idex_stall, id_stall, exmem_stall, branch_interception.
- Arbitrates the single memory-controller port between instruction fetch and MEM-stage load/store.
- Holds a taken-branch redirect until the fetch path can accept it.

Parameters:
ADDR_W, 32, width of instruction address / branch target
MEM_PRIO, 1, 1 = MEM request wins over IF when both are pending in IDLE

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets)
if_req  in  1  IF stage requests an instruction fetch
mem_req  in  1  MEM stage requests a load/store
memctrl_done  in  1  memory controller completes the granted access this cycle
id_load_use  in  1  ID instruction depends on a load currently in EX
ex_branch_taken  in  1  EX resolved a taken branch/jump (mispredict)
ex_branch_target  in  ADDR_W  redirect target from EX
grant_if  out  1  memory port granted to IF (registered)
grant_mem  out  1  memory port granted to MEM (registered)
if_data_valid  out  1  completed fetch is valid, not squashed
if_stall  out  1  hold PC/IF
ifid_stall  out  1  hold IF/ID register
idex_stall  out  1  hold ID/EX register unchanged
id_stall  out  1  ID/EX loads a bubble instead of ID outputs
exmem_stall  out  1  hold EX/MEM register
branch_interception  out  1  flush IF/ID and ID/EX this edge
pc_redirect  out  1  load PC from pc_target (registered)
pc_target  out  ADDR_W  redirect address

Behaviour:
- Reset: arbiter state IDLE; grant_if, grant_mem, pc_redirect, drop_fetch, redirect_pending, if_data_valid = 0; pc_target = 0. Combinational outputs follow from this state.
- Reset mid-access: any in-flight grant is abandoned.
- Arbiter FSM, states IDLE, SERVE_IF, SERVE_MEM:
  - IDLE + mem_req -> SERVE_MEM (if MEM_PRIO=1 or !if_req).
  - IDLE + if_req -> SERVE_IF.
  - Grant registers assert the cycle after entry and stay high until memctrl_done.
  - SERVE_x + memctrl_done -> IDLE; the grant drops the next cycle.
  - Minimum one IDLE cycle between accesses, so back-to-back requests see 1 dead cycle.
- mem_busy = mem_req && !(state==SERVE_MEM && memctrl_done).
- Stall priority, highest first:
  1. mem_busy: if_stall = ifid_stall = idex_stall = exmem_stall = 1; id_stall = 0; branch_interception = 0.
  2. ex_branch_taken: branch_interception = 1; all stalls 0; id_stall = 0.
  3. id_load_use: id_stall = 1, if_stall = 1, ifid_stall = 1, idex_stall = 0 (exactly one bubble per asserted cycle).
  4. state==SERVE_IF && !memctrl_done: if_stall = 1 only.
  5. Otherwise all 0.
- Branch deferred under a MEM stall: EX is frozen, so ex_branch_taken stays high and the branch is taken when the stall releases. It is never dropped and never issued twice.
- On branch_interception:
  - pc_target <= ex_branch_target; redirect_pending <= 1.
  - If state==SERVE_IF with no memctrl_done this cycle, drop_fetch <= 1.
- Redirect issue: pc_redirect is a 1-cycle registered pulse, raised when redirect_pending && state!=SERVE_IF; redirect_pending clears on issue.
- A second branch while a redirect is pending overwrites pc_target; only one pulse is issued.
- if_data_valid = memctrl_done && state==SERVE_IF && !drop_fetch.
- drop_fetch clears on that memctrl_done.
- Branch and memctrl_done for a fetch in the same cycle: the fetch is valid but flushed by branch_interception; drop_fetch is not set.
- memctrl_done while IDLE is ignored.

Decomposition:
- Shared defines header: ADDR_W-compatible `InstAddrBus`; arbiter state encodings `ArbIdle`, `ArbIf`, `ArbMem`.
- One sub-module, mem_arbiter: the FSM plus grant registers, exposing state and memctrl_done-qualified completion.
- pipe_ctrl keeps the stall priority logic and the redirect/drop bookkeeping.

Test Plan:
- Reset: rst=0 for 2 cycles with if_req=1 -> all outputs 0. Release -> grant_if=1 two cycles after release; memctrl_done -> grant_if=0 next cycle, if_data_valid=1 in the done cycle.
- Simultaneous if_req=1, mem_req=1 in IDLE, MEM_PRIO=1 -> grant_mem first. All four stalls =1 until memctrl_done; then grant_if is issued after one IDLE cycle.
- id_load_use=1 for 1 cycle, no other events -> id_stall=1, if_stall=1, ifid_stall=1, idex_stall=0 for exactly that cycle.
- ex_branch_taken=1, target 0x0000_1040, during SERVE_IF with done 3 cycles later:
  - branch_interception=1 for 1 cycle.
  - if_data_valid=0 at done.
  - pc_redirect pulse with pc_target=0x1040 the cycle after state returns IDLE.
- ex_branch_taken held during a MEM stall -> branch_interception=0 until memctrl_done. Then exactly one branch_interception and one pc_redirect.
- Two taken branches (0x100, then 0x200) before a redirect issues -> a single pc_redirect with pc_target=0x200.
